initializer: RTL and testbench

INITIALIZER -- requirements
Module: initializer

---
 rtl/initializer_pkg.sv | 75 +++++++
 rtl/ahb_if.sv | 29 ++
 rtl/initializer.sv | 116 +++++++++++
 tb/tb_initializer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/initializer_pkg.sv
// Shared definitions for the configuration initializer: FSM states, the
// tag codes carried in hrdata[31:29], and the AHB encodings it uses.
package initializer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    READADD1, READWIDTH,
    READADD2, READHEIGHT,
    READADD3, READRSA,
    READADD4, READWSA,
    READADD5, READFILTER,
    KICKSTART
  } state_e;

  localparam logic [2:0]  TAG_WIDTH     = 3'b001;
  localparam logic [2:0]  TAG_HEIGHT    = 3'b010;
  localparam logic [2:0]  TAG_RSA       = 3'b011;
  localparam logic [2:0]  TAG_WSA       = 3'b100;
  localparam logic [2:0]  TAG_FILTER    = 3'b101;

  localparam logic [31:0] CONFIG_ADDR   = 32'h0000_0D09;
  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0]  HBURST_SINGLE = 3'b000;
  localparam logic [1:0]  HRESP_OKAY    = 2'b00;

  // Tag a data phase must see before its payload is accepted.
  function automatic logic [2:0] expected_tag(state_e s);
    case (s)
      READWIDTH:  return TAG_WIDTH;
      READHEIGHT: return TAG_HEIGHT;
      READRSA:    return TAG_RSA;
      READWSA:    return TAG_WSA;
      READFILTER: return TAG_FILTER;
      default:    return 3'b000;
    endcase
  endfunction

  // Data phase that follows a granted address phase.
  function automatic state_e addr_to_data(state_e s);
    case (s)
      READADD1: return READWIDTH;
      READADD2: return READHEIGHT;
      READADD3: return READRSA;
      READADD4: return READWSA;
      READADD5: return READFILTER;
      default:  return IDLE;
    endcase
  endfunction

  // Address phase to reissue when a data phase is rejected.
  function automatic state_e data_to_retry(state_e s);
    case (s)
      READWIDTH:  return READADD1;
      READHEIGHT: return READADD2;
      READRSA:    return READADD3;
      READWSA:    return READADD4;
      READFILTER: return READADD5;
      default:    return IDLE;
    endcase
  endfunction

  // Next step once a data phase has been accepted.
  function automatic state_e data_to_next(state_e s);
    case (s)
      READWIDTH:  return READADD2;
      READHEIGHT: return READADD3;
      READRSA:    return READADD4;
      READWSA:    return READADD5;
      READFILTER: return KICKSTART;
      default:    return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ahb_if.sv
// AHB master-side signal bundle used by the initializer.
interface ahb_if #(
  parameter int BUSWIDTH = 32
);
  logic [1:0]          ahb_htrans;
  logic [2:0]          ahb_hburst;
  logic                ahb_hwrite;
  logic                ahb_hprot;
  logic [BUSWIDTH-1:0] ahb_haddr;
  logic [BUSWIDTH-1:0] ahb_hwdata;
  logic [BUSWIDTH-1:0] ahb_hrdata;
  logic                ahb_hgrant;
  logic                ahb_hlock;
  logic                ahb_hbusreq;
  logic                ahb_hready;
  logic [1:0]          ahb_hresp;

  modport master (
    output ahb_htrans, ahb_hburst, ahb_hwrite, ahb_hprot, ahb_haddr,
           ahb_hwdata, ahb_hlock, ahb_hbusreq,
    input  ahb_hrdata, ahb_hgrant, ahb_hready, ahb_hresp
  );

  modport slave (
    input  ahb_htrans, ahb_hburst, ahb_hwrite, ahb_hprot, ahb_haddr,
           ahb_hwdata, ahb_hlock, ahb_hbusreq,
    output ahb_hrdata, ahb_hgrant, ahb_hready, ahb_hresp
  );
endinterface

// File: rtl/initializer.sv
// Reads five tagged configuration words from a fixed AHB address, retrying
// each until its tag matches with an OKAY response, then raises final_enable.
module initializer
  import initializer_pkg::*;
#(
  parameter int BUSWIDTH = 32
) (
  input  logic                ahb_hclk,
  input  logic                n_rst,
  ahb_if.master               bus,
  output logic [BUSWIDTH-1:0] width,
  output logic [BUSWIDTH-1:0] height,
  output logic [BUSWIDTH-1:0] readStartAddress,
  output logic [BUSWIDTH-1:0] writeStartAddress,
  output logic                filterType,
  output logic                final_enable
);

  state_e              state_q, state_d;
  logic [BUSWIDTH-1:0] width_q, width_d;
  logic [BUSWIDTH-1:0] height_q, height_d;
  logic [BUSWIDTH-1:0] rsa_q, rsa_d;
  logic [BUSWIDTH-1:0] wsa_q, wsa_d;
  logic                filter_q, filter_d;
  logic [BUSWIDTH-1:0] payload;
  logic                accept;

  assign payload = BUSWIDTH'(bus.ahb_hrdata[28:0]);
  assign accept  = (bus.ahb_hrdata[31:29] == expected_tag(state_q)) &&
                   (bus.ahb_hresp == HRESP_OKAY);

  // Fixed single-beat read attributes.
  assign bus.ahb_hburst = HBURST_SINGLE;
  assign bus.ahb_hwrite = 1'b0;
  assign bus.ahb_hwdata = '0;
  assign bus.ahb_hlock  = 1'b0;

  // State and configuration registers.
  always_ff @(posedge ahb_hclk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      rsa_q    <= '0;
      wsa_q    <= '0;
      filter_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      rsa_q    <= rsa_d;
      wsa_q    <= wsa_d;
      filter_q <= filter_d;
    end
  end

  // Next-state, register loads and bus outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d         = state_q;
    width_d         = width_q;
    height_d        = height_q;
    rsa_d           = rsa_q;
    wsa_d           = wsa_q;
    filter_d        = filter_q;
    bus.ahb_htrans  = HTRANS_IDLE;
    bus.ahb_haddr   = '0;
    bus.ahb_hprot   = 1'b0;
    bus.ahb_hbusreq = 1'b0;

    unique case (state_q)
      IDLE: state_d = READADD1;

      READADD1, READADD2, READADD3, READADD4, READADD5: begin
        bus.ahb_hbusreq = 1'b1;
        if (bus.ahb_hgrant && bus.ahb_hready) begin
          bus.ahb_htrans = HTRANS_NONSEQ;
          bus.ahb_haddr  = BUSWIDTH'(CONFIG_ADDR);
          bus.ahb_hprot  = 1'b1;
          state_d        = addr_to_data(state_q);
        end
      end

      READWIDTH, READHEIGHT, READRSA, READWSA, READFILTER: begin
        bus.ahb_hbusreq = 1'b1;
        if (bus.ahb_hready) begin
          if (accept) begin
            case (state_q)
              READWIDTH:  width_d  = payload;
              READHEIGHT: height_d = payload;
              READRSA:    rsa_d    = payload;
              READWSA:    wsa_d    = payload;
              default:    filter_d = bus.ahb_hrdata[0];
            endcase
            state_d = data_to_next(state_q);
          end else begin
            state_d = data_to_retry(state_q);
          end
        end
      end

      KICKSTART: ;

      default: state_d = IDLE;
    endcase
  end

  assign width             = width_q;
  assign height            = height_q;
  assign readStartAddress  = rsa_q;
  assign writeStartAddress = wsa_q;
  assign filterType        = filter_q;
  assign final_enable      = (state_q == KICKSTART);

endmodule

// File: tb/tb_initializer.sv
// Bench for the initializer: directed scenarios plus randomized bus behaviour,
// all checked cycle by cycle against a field-counter reference model.
module tb_initializer;

  logic clk;
  logic n_rst;
  logic [31:0] width, height, rsa, wsa;
  logic filter_type, final_enable;

  ahb_if #(.BUSWIDTH(32)) bus ();

  initializer #(.BUSWIDTH(32)) dut (
    .ahb_hclk          (clk),
    .n_rst             (n_rst),
    .bus               (bus.master),
    .width             (width),
    .height            (height),
    .readStartAddress  (rsa),
    .writeStartAddress (wsa),
    .filterType        (filter_type),
    .final_enable      (final_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: which field (1..5) is being fetched, 0 before the first
  // clock after reset, 6 once all fields are in; plus whether a read is in flight.
  int          m_field;
  bit          m_in_flight;
  logic [31:0] m_val [1:5];

  task automatic model_reset();
    m_field     = 0;
    m_in_flight = 0;
    for (int i = 1; i <= 5; i++) m_val[i] = '0;
  endtask

  task automatic check_cfg(input string pfx);
    check({pfx, "_width"},  width,        m_val[1]);
    check({pfx, "_height"}, height,       m_val[2]);
    check({pfx, "_rsa"},    rsa,          m_val[3]);
    check({pfx, "_wsa"},    wsa,          m_val[4]);
    check({pfx, "_filter"}, filter_type,  m_val[5][0]);
    check({pfx, "_final"},  final_enable, m_field == 6);
  endtask

  task automatic check_reset_outputs();
    check("rst_htrans",  bus.ahb_htrans,  2'b00);
    check("rst_haddr",   bus.ahb_haddr,   32'h0);
    check("rst_hbusreq", bus.ahb_hbusreq, 1'b0);
    check("rst_width",   width,           32'h0);
    check("rst_height",  height,          32'h0);
    check("rst_rsa",     rsa,             32'h0);
    check("rst_wsa",     wsa,             32'h0);
    check("rst_filter",  filter_type,     1'b0);
    check("rst_final",   final_enable,    1'b0);
  endtask

  // Called at posedge+1; leaves at posedge+1 with reset released.
  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  // One bus cycle: drive at posedge+1, check at negedge, advance the model.
  task automatic run_cycle(input bit g, input bit r, input logic [1:0] resp,
                           input logic [31:0] rd);
    bit busy, addr_now;
    bus.ahb_hgrant = g;
    bus.ahb_hready = r;
    bus.ahb_hresp  = resp;
    bus.ahb_hrdata = rd;
    @(negedge clk);
    busy     = (m_field >= 1) && (m_field <= 5);
    addr_now = busy && !m_in_flight && g && r;
    check("htrans",  bus.ahb_htrans,  addr_now ? 2'b10 : 2'b00);
    check("haddr",   bus.ahb_haddr,   addr_now ? 32'h0000_0D09 : 32'h0);
    check("hprot",   bus.ahb_hprot,   addr_now);
    check("hbusreq", bus.ahb_hbusreq, busy);
    check("hwrite",  bus.ahb_hwrite,  1'b0);
    check("hburst",  bus.ahb_hburst,  3'b000);
    check("hwdata",  bus.ahb_hwdata,  32'h0);
    check("hlock",   bus.ahb_hlock,   1'b0);
    check_cfg("cyc");
    if (m_field == 0) begin
      m_field = 1;
    end else if (busy && !m_in_flight) begin
      if (g && r) m_in_flight = 1;
    end else if (busy && r) begin
      m_in_flight = 0;
      if (rd[31:29] == 3'(m_field) && resp == 2'b00) begin
        m_val[m_field] = (m_field == 5) ? {31'h0, rd[0]} : {3'b000, rd[28:0]};
        m_field++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          g;
    bit          r;
    logic [1:0]  resp;
    logic [31:0] rd;
  } stim_t;

  stim_t dir_q[$];

  function automatic stim_t mk(bit g, bit r, logic [1:0] resp, logic [31:0] rd);
    stim_t s;
    s.g = g; s.r = r; s.resp = resp; s.rd = rd;
    return s;
  endfunction

  initial begin
    n_rst          = 1'b0;
    bus.ahb_hgrant = 1'b0;
    bus.ahb_hready = 1'b0;
    bus.ahb_hresp  = 2'b00;
    bus.ahb_hrdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    n_rst = 1'b1;

    // Directed: grant stall, ready stall, wrong-tag retry, full sequence.
    dir_q.push_back(mk(1, 1, 2'b00, 32'h0));
    repeat (5) dir_q.push_back(mk(0, 1, 2'b00, 32'h0));
    dir_q.push_back(mk(1, 1, 2'b00, 32'h0));
    repeat (3) dir_q.push_back(mk(1, 0, 2'b00, 32'h2000_0151));
    dir_q.push_back(mk(1, 1, 2'b00, 32'h2000_0151));
    dir_q.push_back(mk(1, 1, 2'b00, 32'h0));
    dir_q.push_back(mk(1, 1, 2'b00, 32'h6000_0001));
    dir_q.push_back(mk(1, 1, 2'b00, 32'h0));
    dir_q.push_back(mk(1, 1, 2'b00, 32'h4000_0151));
    dir_q.push_back(mk(1, 1, 2'b00, 32'h0));
    dir_q.push_back(mk(1, 1, 2'b00, 32'h6000_01F4));
    dir_q.push_back(mk(1, 1, 2'b00, 32'h0));
    dir_q.push_back(mk(1, 1, 2'b00, 32'h8000_157C));
    dir_q.push_back(mk(1, 1, 2'b00, 32'h0));
    dir_q.push_back(mk(1, 1, 2'b00, 32'hA000_0001));
    repeat (3) dir_q.push_back(mk(1, 1, 2'b00, 32'h2000_0777));
    foreach (dir_q[i]) run_cycle(dir_q[i].g, dir_q[i].r, dir_q[i].resp, dir_q[i].rd);
    check("dir_width",  width,        32'h151);
    check("dir_height", height,       32'h151);
    check("dir_rsa",    rsa,          32'h1F4);
    check("dir_wsa",    wsa,          32'h157C);
    check("dir_filter", filter_type,  1'b1);
    check("dir_final",  final_enable, 1'b1);

    // Directed: reset while waiting in the write-start-address data phase.
    do_reset();
    run_cycle(1, 1, 2'b00, 32'h0);
    run_cycle(1, 1, 2'b00, 32'h0);
    run_cycle(1, 1, 2'b00, 32'h2000_0010);
    run_cycle(1, 1, 2'b00, 32'h0);
    run_cycle(1, 1, 2'b00, 32'h4000_0020);
    run_cycle(1, 1, 2'b00, 32'h0);
    run_cycle(1, 1, 2'b00, 32'h6000_0030);
    run_cycle(1, 1, 2'b00, 32'h0);
    check("pre_rst_rsa", rsa, 32'h30);
    do_reset();
    run_cycle(1, 1, 2'b00, 32'h0);
    run_cycle(1, 1, 2'b00, 32'h0);

    // Randomized: stalls, bad tags, error responses, occasional resets.
    for (int run = 0; run < 25; run++) begin
      int done_cycles;
      do_reset();
      done_cycles = 0;
      for (int cyc = 0; cyc < 400 && done_cycles < 4; cyc++) begin
        bit          g, r;
        logic [1:0]  resp;
        logic [2:0]  tag;
        logic [31:0] rd;
        g    = ($urandom_range(0, 3) != 0);
        r    = ($urandom_range(0, 3) != 0);
        resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        tag  = ($urandom_range(0, 3) != 0) ? 3'(m_field) : 3'($urandom_range(0, 7));
        rd   = {tag, 29'($urandom)};
        run_cycle(g, r, resp, rd);
        if (m_field == 6) done_cycles++;
        if ($urandom_range(0, 149) == 0) do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
